// File: rtl/rf_access_sequencer.sv
// Register-file access sequencer: fetch two operands, hand them to the ALU, retire one result.
// Build option RF_ZERO_REG_EN makes register 0 read as zero and suppresses writes to it.
module rf_access_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic              instr_wb,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_RES, WB} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic              wb_q;
  logic [7:0]        wd_cnt;
  logic [DATA_W-1:0] fetch_a;
  logic [DATA_W-1:0] fetch_b;
  logic              wb_en;

`ifdef RF_ZERO_REG_EN
  always_comb begin
    fetch_a = (rf_read_reg1 == '0) ? '0 : rf_read_data1;
    fetch_b = (rf_read_reg2 == '0) ? '0 : rf_read_data2;
    wb_en   = wb_q && (rf_write_reg != '0);
  end
`else
  always_comb begin
    fetch_a = rf_read_data1;
    fetch_b = rf_read_data2;
    wb_en   = wb_q;
  end
`endif

  // Latched rs1/rs2/rd/result double as the read/write address and data ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      instr_ready   <= 1'b1;
      busy          <= 1'b0;
      rf_read_reg1  <= '0;
      rf_read_reg2  <= '0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      rf_reg_write  <= 1'b0;
      op_valid      <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      timeout_err   <= 1'b0;
      wb_q          <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            rf_read_reg1 <= instr_rs1;
            rf_read_reg2 <= instr_rs2;
            rf_write_reg <= instr_rd;
            wb_q         <= instr_wb;
            instr_ready  <= 1'b0;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          op_a     <= fetch_a;
          op_b     <= fetch_b;
          op_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            wd_cnt   <= '0;
            state    <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // A result arriving on the final watchdog cycle takes priority over the abort.
          if (res_valid) begin
            rf_write_data <= res_data;
            if (wb_q) begin
              rf_reg_write <= wb_en;
              state        <= WB;
            end else begin
              instr_ready <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        WB: begin
          rf_reg_write <= 1'b0;
          instr_ready  <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Self-checking bench for rf_access_sequencer: directed scenarios plus randomized transactions
// against a transaction-level model of the register file and ALU handshake.
module tb_rf_access_sequencer;

  localparam int unsigned TB_TIMEOUT = 4;
`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_rs1;
  logic [3:0] instr_rs2;
  logic [3:0] instr_rd;
  logic       instr_wb;
  logic [3:0] rf_read_reg1;
  logic [3:0] rf_read_reg2;
  logic [7:0] rf_read_data1;
  logic [7:0] rf_read_data2;
  logic [3:0] rf_write_reg;
  logic [7:0] rf_write_data;
  logic       rf_reg_write;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       res_valid;
  logic [7:0] res_data;
  logic       busy;
  logic       timeout_err;

  rf_access_sequencer #(
    .DATA_W (8),
    .ADDR_W (4),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .instr_rd     (instr_rd),
    .instr_wb     (instr_wb),
    .rf_read_reg1 (rf_read_reg1),
    .rf_read_reg2 (rf_read_reg2),
    .rf_read_data1(rf_read_data1),
    .rf_read_data2(rf_read_data2),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data),
    .rf_reg_write (rf_reg_write),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // Register file contents, written only by the bench according to the model.
  logic [7:0] rf [16];
  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned wr_cnt = 0;
  int unsigned xfer_cnt = 0;
  int unsigned exp_wr = 0;
  logic        exp_err = 1'b0;
  bit          have_prev = 1'b0;
  int unsigned prev_acc = 0;
  int unsigned exp_spacing = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_reg_write === 1'b1) wr_cnt <= wr_cnt + 1;
    if (op_valid === 1'b1 && op_ready === 1'b1) xfer_cnt <= xfer_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete instruction, entered and left at a negedge while the DUT sits in IDLE.
  task automatic run_txn(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic wb, input int unsigned rdy_dly, input int unsigned res_dly,
                         input logic [7:0] res);
    logic [7:0]  ea;
    logic [7:0]  eb;
    bit          wr_eff;
    bit          timed_out;
    int unsigned acc;
    int unsigned x0;
    ea        = (ZERO_EN && rs1 == 4'd0) ? 8'h00 : rf[rs1];
    eb        = (ZERO_EN && rs2 == 4'd0) ? 8'h00 : rf[rs2];
    wr_eff    = wb && !(ZERO_EN && rd == 4'd0);
    timed_out = (res_dly >= TB_TIMEOUT);

    chk("idle_ready", instr_ready, 1);
    chk("idle_busy", busy, 0);
    instr_valid = 1'b1;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    instr_rd    = rd;
    instr_wb    = wb;
    step();
    instr_valid = 1'b0;
    instr_rs1   = 4'($urandom);
    instr_rs2   = 4'($urandom);
    instr_rd    = 4'($urandom);
    instr_wb    = 1'($urandom);
    acc = cyc;
    if (have_prev) chk("accept_spacing", acc - prev_acc, exp_spacing);
    prev_acc = acc;

    chk("fetch_busy", busy, 1);
    chk("fetch_ready", instr_ready, 0);
    chk("fetch_rd1", rf_read_reg1, rs1);
    chk("fetch_rd2", rf_read_reg2, rs2);
    chk("fetch_opv", op_valid, 0);
    step();

    x0 = xfer_cnt;
    for (int unsigned i = 0; i < rdy_dly; i++) begin
      chk("issue_wait_opv", op_valid, 1);
      chk("issue_wait_a", op_a, ea);
      chk("issue_wait_b", op_b, eb);
      res_valid = 1'($urandom);
      res_data  = 8'($urandom);
      step();
    end
    chk("issue_opv", op_valid, 1);
    chk("issue_a", op_a, ea);
    chk("issue_b", op_b, eb);
    op_ready = 1'b1;
    step();
    op_ready  = 1'b0;
    res_valid = 1'b0;
    chk("wait_opv", op_valid, 0);
    chk("xfer_once", xfer_cnt, x0 + 1);

    for (int unsigned k = 0; k < (timed_out ? TB_TIMEOUT : res_dly); k++) begin
      chk("wait_busy", busy, 1);
      chk("wait_nowrite", rf_reg_write, 0);
      step();
    end

    if (timed_out) begin
      exp_err = 1'b1;
      chk("tmo_err", timeout_err, 1);
      chk("tmo_ready", instr_ready, 1);
      chk("tmo_busy", busy, 0);
      exp_spacing = 3 + rdy_dly + TB_TIMEOUT;
    end else begin
      res_valid = 1'b1;
      res_data  = res;
      step();
      res_valid = 1'b0;
      res_data  = 8'($urandom);
      if (wb) begin
        chk("wb_busy", busy, 1);
        chk("wb_ready", instr_ready, 0);
        chk("wb_strobe", rf_reg_write, wr_eff);
        if (wr_eff) begin
          chk("wb_addr", rf_write_reg, rd);
          chk("wb_data", rf_write_data, res);
          exp_wr++;
        end
        step();
        if (wr_eff) rf[rd] = res;
      end
      chk("done_ready", instr_ready, 1);
      chk("done_busy", busy, 0);
      chk("done_nowrite", rf_reg_write, 0);
      exp_spacing = 4 + rdy_dly + res_dly + (wb ? 1 : 0);
    end
    chk("err_sticky", timeout_err, exp_err);
    chk("write_count", wr_cnt, exp_wr);
    have_prev = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    instr_rd    = '0;
    instr_wb    = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_write", rf_reg_write, 0);
    chk("rst_opv", op_valid, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_rd1", rf_read_reg1, 0);

    rf[2] = 8'h05;
    rf[3] = 8'h07;
    run_txn(4'd2, 4'd3, 4'd4, 1'b1, 0, 0, 8'h0C);
    run_txn(4'd2, 4'd3, 4'd4, 1'b0, 0, 0, 8'h0C);
    run_txn(4'd2, 4'd3, 4'd5, 1'b1, 6, 0, 8'h33);

    run_txn(4'd1, 4'd2, 4'd6, 1'b1, 0, TB_TIMEOUT + 5, 8'hEE);
    run_txn(4'd6, 4'd7, 4'd8, 1'b1, 1, TB_TIMEOUT - 1, 8'h5A);

    rf[0] = 8'h05;
    run_txn(4'd0, 4'd3, 4'd0, 1'b1, 0, 0, 8'hAA);

    for (int n = 0; n < 40; n++) begin
      int unsigned rdy;
      int unsigned rsd;
      rdy = $urandom_range(0, 3);
      rsd = ($urandom_range(0, 4) == 0) ? TB_TIMEOUT + $urandom_range(0, 2)
                                        : $urandom_range(0, TB_TIMEOUT - 1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          rf[$urandom_range(0, 15)] = 8'($urandom);
          step();
        end
        have_prev = 1'b0;
      end
      run_txn(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), rdy, rsd, 8'($urandom));
    end

    instr_valid = 1'b1;
    instr_rs1   = 4'd9;
    instr_rs2   = 4'd10;
    instr_rd    = 4'd11;
    instr_wb    = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("pre_rst_opv", op_valid, 1);
    rst_n = 1'b0;
    step();
    exp_err   = 1'b0;
    have_prev = 1'b0;
    chk("midrst_opv", op_valid, 0);
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", timeout_err, 0);
    chk("midrst_rd1", rf_read_reg1, 0);
    chk("midrst_wreg", rf_write_reg, 0);
    chk("midrst_wdata", rf_write_data, 0);
    chk("midrst_opa", op_a, 0);
    rst_n = 1'b1;
    step();
    run_txn(4'd9, 4'd10, 4'd11, 1'b1, 0, 1, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_access_sequencer.md
Name: rf_access_sequencer

Overview:
- Initiator side of the 8-bit, 16-entry register file interface.
- Accepts one decoded instruction at a time: rs1, rs2, rd and a writeback flag.
- Fetches both operands from the register file, hands them to the ALU with a valid/ready handshake, and waits for the result.
- Drives the register-file write port for exactly one cycle to retire the result; a watchdog aborts if the ALU never answers.

Parameters:
- DATA_W, 8, register data width; must match the register file word.
- ADDR_W, 4, register index width (16 registers).
- TIMEOUT, 32, maximum cycles spent in WAIT_RES before abort; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr_valid  in  1  upstream instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_rs1  in  ADDR_W  source register A.
- instr_rs2  in  ADDR_W  source register B.
- instr_rd  in  ADDR_W  destination register.
- instr_wb  in  1  1 = write result to instr_rd.
- rf_read_reg1  out  ADDR_W  register file read address 1.
- rf_read_reg2  out  ADDR_W  register file read address 2.
- rf_read_data1  in  DATA_W  register file read data 1 (combinational).
- rf_read_data2  in  DATA_W  register file read data 2 (combinational).
- rf_write_reg  out  ADDR_W  register file write address.
- rf_write_data  out  DATA_W  register file write data.
- rf_reg_write  out  1  register file write enable.
- op_valid  out  1  operands valid to ALU.
- op_ready  in  1  ALU accepts operands.
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- res_valid  in  1  ALU result present (single-cycle pulse is sufficient).
- res_data  in  DATA_W  ALU result.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset.

Behaviour:
- Reset (rst_n low at a clk edge) applies in any state, including mid-transaction:
  - state = IDLE; all outputs 0 except instr_ready = 1.
  - Latched rs1/rs2/rd/wb/operands/result and watchdog counter all cleared.
- States: IDLE, FETCH, ISSUE, WAIT_RES, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch rs1, rs2, rd, wb -> FETCH.
- FETCH (exactly 1 cycle):
  - rf_read_reg1/2 = latched rs1/rs2.
  - At the edge, capture rf_read_data1/2 into op_a/op_b -> ISSUE.
  - rf_read_reg1/2 hold their last value outside FETCH; 0 after reset.
- ISSUE:
  - op_valid = 1; op_a/op_b held stable.
  - On op_ready -> WAIT_RES. op_valid drops the next cycle; no combinational op_ready -> op_valid path.
  - Clear the watchdog counter on entry to WAIT_RES.
- WAIT_RES:
  - Counter increments each cycle.
  - On res_valid: latch res_data, go to WB if wb = 1, else IDLE.
  - If counter reaches TIMEOUT-1 with no res_valid: set timeout_err, go to IDLE, no write.
  - res_valid and the timeout on the same cycle: the result wins.
- WB (exactly 1 cycle):
  - rf_reg_write = 1, rf_write_reg = rd, rf_write_data = latched result -> IDLE.
- res_valid outside WAIT_RES is ignored.
- Instruction throughput:
  - Minimum latency, accept to write strobe = 4 cycles (op_ready and res_valid both immediate).
  - Back-to-back accept every 5 cycles; instr_ready deasserted in all non-IDLE states.
- rd == rs1 or rd == rs2 needs no forwarding; transactions are strictly serial.
- Widths: no arithmetic on data; the watchdog counter is 8 bits and saturates.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired zero from the sequencer's view.
  - In FETCH, an operand whose address is 0 is captured as 0 regardless of rf_read_data.
  - WB to rd = 0 still takes its cycle but holds rf_reg_write = 0.
- Undefined: register 0 is ordinary; reads and writes pass through.

Test Plan:
- Reset, then idle for 3 cycles -> instr_ready = 1, busy = 0, rf_reg_write = 0, op_valid = 0, timeout_err = 0.
- rf[2] = 0x05, rf[3] = 0x07; instr rs1 = 2, rs2 = 3, rd = 4, wb = 1; op_ready = 1; ALU returns 0x0C one cycle later:
  - op_a = 0x05, op_b = 0x07.
  - Single rf_reg_write pulse with rf_write_reg = 4, rf_write_data = 0x0C.
  - Next instruction accepted 5 cycles after the first.
- Same as above with wb = 0 -> no rf_reg_write pulse; returns to IDLE the cycle after res_valid.
- op_ready held low 6 cycles, then high -> op_valid stays high and op_a/op_b stable for all 7 cycles; exactly one transfer.
- TIMEOUT = 4, res_valid never asserted -> timeout_err = 1 after 4 WAIT_RES cycles; back in IDLE, no write. rst_n low mid-ISSUE -> IDLE next edge, op_valid = 0.
- RF_ZERO_REG_EN defined, rf[0] = 0x05, rs1 = 0, rd = 0 -> op_a = 0x00; WB cycle occurs with rf_reg_write = 0.
